// File: rtl/prog_loader.sv
// Instruction-memory loader: receives a framed byte stream, writes assembled words
// into instruction memory and releases the core from reset only after a clean checksum.
module prog_loader #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               core_rst,
    output logic               done,
    output logic               err,
    output logic [ADDR_W:0]    load_count
);

    localparam int unsigned BPI    = INSTR_W / 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned BIDX_W = (BPI > 1) ? $clog2(BPI) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                rx_ready_q, rx_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic                core_rst_q, core_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [7:0]          sum_q, sum_d;
    logic [BIDX_W-1:0]   bidx_q, bidx_d;
    logic [INSTR_W-1:0]  asm_q, asm_d;

    logic                xfer_c;
    logic [INSTR_W-1:0]  word_c;

    assign xfer_c = rx_valid && rx_ready_q;
    assign word_c = INSTR_W'({asm_q, rx_data});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            bidx_q      <= '0;
            asm_q       <= '0;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= rx_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_rst_q  <= core_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            bidx_q      <= bidx_d;
            asm_q       <= asm_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rx_ready_d  = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        core_rst_d  = core_rst_q;
        done_d      = done_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        sum_d       = sum_q;
        bidx_d      = bidx_q;
        asm_d       = asm_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                // Only SYNC leaves these states; everything else is dropped
                if (xfer_c && rx_data == SYNC) begin
                    state_d    = LEN;
                    sum_d      = '0;
                    cnt_d      = '0;
                    bidx_d     = '0;
                    core_rst_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end
            LEN: begin
                if (xfer_c) begin
                    if (rx_data == 8'h00 || 32'(rx_data) > DEPTH) begin
                        state_d    = ERR;
                        err_d      = 1'b1;
                        core_rst_d = 1'b1;
                    end else begin
                        len_d   = CNT_W'(rx_data);
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // The write cycle doubles as the single bubble per instruction
                if (mem_we_q) begin
                    if (cnt_q == len_q) begin
                        state_d = CSUM;
                    end
                end else if (xfer_c) begin
                    asm_d = word_c;
                    sum_d = sum_q + rx_data;
                    if (bidx_q == BIDX_W'(BPI - 1)) begin
                        bidx_d      = '0;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cnt_q[ADDR_W-1:0];
                        mem_wdata_d = word_c;
                        cnt_d       = cnt_q + CNT_W'(1);
                        rx_ready_d  = 1'b0;
                    end else begin
                        bidx_d = bidx_q + BIDX_W'(1);
                    end
                end
            end
            CSUM: begin
                if (xfer_c) begin
                    if (rx_data == sum_q) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else begin
                        state_d    = ERR;
                        err_d      = 1'b1;
                        core_rst_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_ready   = rx_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign err        = err_q;
    assign load_count = cnt_q;

endmodule
